l2_assoc_controller: RTL
========================

# l2_assoc_controller

Parametrised set-associative L2 controller with internal tag/state/data arrays, per-set true-LRU replacement, write-back of dirty victims and write-allocate on misses. Sits between the snooping bus (one request at a time from the L1 side) and main memory, using the same valid/ready request and valid-only response conventions as the existing L2 path. It generalises the direct-mapped controller to WAYS ways and SETS sets and fixes write-miss handling: dirty victims are always written back before being replaced.

## Interface
- ADDR_W, 6, line address width (byte offset already stripped)
- DATA_W, 8, cacheline data width
- WAYS, 2, associativity; power of two, ≥1
- SETS, 16, number of sets; power of two, ≥2; INDEX_W = $clog2(SETS), TAG_W = ADDR_W-INDEX_W
- clk  in  1  single clock
- reset  in  1  one clock; reset is synchronous and active-high
- req_valid  in  1  bus request valid
- req_ready  out  1  controller can accept a request
- req_addr  in  ADDR_W  line address; index = [INDEX_W-1:0], tag = upper TAG_W bits
- req_rw  in  1  0 read, 1 write (full-line write)
- req_data  in  DATA_W  write data
- resp_valid  out  1  one-cycle read-response strobe
- resp_data  out  DATA_W  read data, valid with resp_valid
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_rw  out  1  0 read, 1 write-back
- mem_req_addr  out  ADDR_W  memory line address
- mem_req_data  out  DATA_W  write-back data
- mem_resp_valid  in  1  fill data valid
- mem_resp_data  in  DATA_W  fill data

## Operation
- Per line: state {I, C (clean), D (dirty)}, tag, data. Per set: one age counter per way, width max(1,$clog2(WAYS)); age 0 = MRU.
- FSM states: IDLE, TAG, WB, FILL_REQ, FILL_WAIT, RESPOND.
- IDLE: req_ready=1; on req_valid latch addr/rw/data, go TAG.
- TAG: compare latched tag against all valid ways of the set.
  - Read hit: capture data, touch way, go RESPOND.
  - Write hit: data←req_data, state←D, touch way, go IDLE.
  - Miss: victim = lowest-index I way, else way with age WAYS-1. If victim D go WB, else go FILL_REQ (read) or install (write: state D, tag, data, touch) and go IDLE.
- WB: mem_req_valid=1, rw=1, addr={victim tag, index}, data=victim data. On mem_req_ready: victim←I; read → FILL_REQ; write → install dirty line in victim way, touch, IDLE.
- FILL_REQ: mem_req_valid=1, rw=0, addr=latched addr; on mem_req_ready → FILL_WAIT.
- FILL_WAIT: on mem_resp_valid install C line in victim way, capture data, touch, → RESPOND.
- RESPOND: resp_valid=1 for exactly one cycle, → IDLE.
- Touch(way w, age a): every way in the set with age < a increments; w←0. Other sets untouched.

## Timing
- Reset (while high and on the following edge): state IDLE, all lines I, way i age←i, req_ready=0, resp_valid=0, resp_data=0, mem_req_valid=0, mem_req_rw=0, mem_req_addr=0, mem_req_data=0. req_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation aborts any memory transaction. mem_req_valid is 0 from the next cycle. Dirty data is discarded.
- Acceptance at cycle 0. Read hit: resp_valid at cycle 2. Write hit or clean-victim write miss: req_ready high again at cycle 2.
- Miss latency adds: 1 cycle minimum per memory request, plus memory response delay.
- mem_req_* fields are held stable while mem_req_valid=1 and mem_req_ready=0. Transfer occurs on the cycle both are high.
- mem_resp_valid outside FILL_WAIT is ignored. resp_data holds its last value between strobes.
- req_valid while req_ready=0 is ignored (no queuing).

## Configuration
- L2_WRITE_NO_ALLOC_EN undefined (default): write-allocate as above.
- L2_WRITE_NO_ALLOC_EN defined: a write miss skips victim selection. A single memory write (rw=1, addr=req addr, data=req data) is issued from WB, then the FSM returns to IDLE. Arrays and ages are unchanged. Write hits are unaffected.

## Test plan
- Defaults, cold read 0x05 → mem read addr 0x05; return 0xA5 → resp_data 0xA5 one cycle. Re-read 0x05 → resp at cycle 2, no mem_req_valid.
- Write 0x15/0x3C, then write 0x25/0x4D (set 5) → no memory traffic. Read 0x25 → 0x4D at cycle 2.
- Continue: read 0x35 → mem write addr 0x15 data 0x3C, then mem read 0x35. Return 0x77 → resp 0x77.
- Hold mem_req_ready=0 for 5 cycles during WB → addr/data/rw stable, then exactly one transfer. Pulse mem_resp_valid in IDLE → ignored.
- Assert reset in FILL_WAIT → mem_req_valid=0 next cycle. Subsequent read 0x25 misses.
- L2_WRITE_NO_ALLOC_EN defined: write miss 0x09/0x11 → one mem write 0x09/0x11. Read 0x09 → miss to memory.

Source files
------------

// File: rtl/l2_assoc_controller.sv
// Set-associative L2 controller: true-LRU per set, write-back of dirty victims, write-allocate.
// Define L2_WRITE_NO_ALLOC_EN to forward write misses straight to memory without allocating.
module l2_assoc_controller #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int WAYS   = 2,
  parameter int SETS   = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_rw_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_req_rw_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [DATA_W-1:0] mem_req_data_o,
  input  logic              mem_resp_valid_i,
  input  logic [DATA_W-1:0] mem_resp_data_i
);
  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - INDEX_W;
  localparam int AGE_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WAY_W   = AGE_W;
  localparam logic [1:0] ST_I = 2'd0, ST_C = 2'd1, ST_D = 2'd2;

  typedef enum logic [2:0] {IDLE, TAG, WB, FILL_REQ, FILL_WAIT, RESPOND} state_e;
  typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;

  state_e                                  state_q;
  logic [SETS-1:0][WAYS-1:0][1:0]          lst_q;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]    tag_q;
  logic [SETS-1:0][WAYS-1:0][DATA_W-1:0]   data_q;
  ages_t [SETS-1:0]                        age_q;

  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WAY_W-1:0]  victim_q;
  logic              req_ready_q, resp_valid_q, mem_req_valid_q, mem_req_rw_q;
  logic [DATA_W-1:0] resp_data_q, mem_req_data_q;
  logic [ADDR_W-1:0] mem_req_addr_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tg;
  logic               hit;
  logic [WAY_W-1:0]   hit_way, victim_d;

  assign idx = addr_q[INDEX_W-1:0];
  assign tg  = addr_q[ADDR_W-1:INDEX_W];

  // Victim: lowest-index invalid way wins over the LRU (oldest) way.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    victim_d = '0;
    for (int w = 0; w < WAYS; w++)
      if (lst_q[idx][w] != ST_I && tag_q[idx][w] == tg) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    for (int w = 0; w < WAYS; w++)
      if (age_q[idx][w] == AGE_W'(WAYS-1)) victim_d = WAY_W'(w);
    for (int w = WAYS-1; w >= 0; w--)
      if (lst_q[idx][w] == ST_I) victim_d = WAY_W'(w);
  end

  function automatic ages_t touched(input ages_t ages, input logic [WAY_W-1:0] w);
    touched = ages;
    for (int j = 0; j < WAYS; j++)
      if (ages[j] < ages[w]) touched[j] = ages[j] + AGE_W'(1);
    touched[w] = '0;
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      lst_q           <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
      addr_q          <= '0;
      rw_q            <= 1'b0;
      wdata_q         <= '0;
      victim_q        <= '0;
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_rw_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_data_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_ready_q && req_valid_i) begin
            addr_q      <= req_addr_i;
            rw_q        <= req_rw_i;
            wdata_q     <= req_data_i;
            req_ready_q <= 1'b0;
            state_q     <= TAG;
          end
        end
        TAG: begin
          if (hit) begin
            age_q[idx] <= touched(age_q[idx], hit_way);
            if (!rw_q) begin
              resp_data_q  <= data_q[idx][hit_way];
              resp_valid_q <= 1'b1;
              state_q      <= RESPOND;
            end else begin
              data_q[idx][hit_way] <= wdata_q;
              lst_q[idx][hit_way]  <= ST_D;
              req_ready_q          <= 1'b1;
              state_q              <= IDLE;
            end
          end
`ifdef L2_WRITE_NO_ALLOC_EN
          else if (rw_q) begin
            mem_req_valid_q <= 1'b1;
            mem_req_rw_q    <= 1'b1;
            mem_req_addr_q  <= addr_q;
            mem_req_data_q  <= wdata_q;
            state_q         <= WB;
          end
`endif
          else begin
            victim_q <= victim_d;
            if (lst_q[idx][victim_d] == ST_D) begin
              mem_req_valid_q <= 1'b1;
              mem_req_rw_q    <= 1'b1;
              mem_req_addr_q  <= {tag_q[idx][victim_d], idx};
              mem_req_data_q  <= data_q[idx][victim_d];
              state_q         <= WB;
            end else if (!rw_q) begin
              mem_req_valid_q <= 1'b1;
              mem_req_rw_q    <= 1'b0;
              mem_req_addr_q  <= addr_q;
              state_q         <= FILL_REQ;
            end else begin
              lst_q[idx][victim_d]  <= ST_D;
              tag_q[idx][victim_d]  <= tg;
              data_q[idx][victim_d] <= wdata_q;
              age_q[idx]            <= touched(age_q[idx], victim_d);
              req_ready_q           <= 1'b1;
              state_q               <= IDLE;
            end
          end
        end
        WB: begin
          if (mem_req_ready_i) begin
`ifdef L2_WRITE_NO_ALLOC_EN
            if (rw_q) begin
              mem_req_valid_q <= 1'b0;
              req_ready_q     <= 1'b1;
              state_q         <= IDLE;
            end else begin
`else
            begin
`endif
              lst_q[idx][victim_q] <= ST_I;
              if (!rw_q) begin
                mem_req_rw_q   <= 1'b0;
                mem_req_addr_q <= addr_q;
                state_q        <= FILL_REQ;
              end else begin
                // Later assignment overrides the invalidate above.
                mem_req_valid_q       <= 1'b0;
                lst_q[idx][victim_q]  <= ST_D;
                tag_q[idx][victim_q]  <= tg;
                data_q[idx][victim_q] <= wdata_q;
                age_q[idx]            <= touched(age_q[idx], victim_q);
                req_ready_q           <= 1'b1;
                state_q               <= IDLE;
              end
            end
          end
        end
        FILL_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (mem_resp_valid_i) begin
            lst_q[idx][victim_q]  <= ST_C;
            tag_q[idx][victim_q]  <= tg;
            data_q[idx][victim_q] <= mem_resp_data_i;
            age_q[idx]            <= touched(age_q[idx], victim_q);
            resp_data_q           <= mem_resp_data_i;
            resp_valid_q          <= 1'b1;
            state_q               <= RESPOND;
          end
        end
        RESPOND: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o     = req_ready_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_data_o     = resp_data_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_rw_o    = mem_req_rw_q;
  assign mem_req_addr_o  = mem_req_addr_q;
  assign mem_req_data_o  = mem_req_data_q;
endmodule
